// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Four-digit seven-segment scan controller with frame-aligned
//            display value updates.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int CNT_W        = $clog2(DIGIT_CYCLES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  digit_en,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [3:0]  hex,
    output logic        pending,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [1:0]       C_SEL_LAST = 2'd3;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [15:0]      r_pend_val;
    logic [15:0]      r_shown;
    logic             r_pending;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_apply;

    assign w_tick  = (r_cnt == C_CNT_MAX);
    // The wrap tick is the only point where the displayed frame may change.
    assign w_apply = w_tick && (r_sel == C_SEL_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_sel        <= '0;
            r_pend_val   <= '0;
            r_shown      <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : (r_cnt + C_CNT_ONE);
            r_frame_done <= w_apply;

            if (w_tick) begin
                r_sel <= r_sel + 2'd1;
            end

            if (load) begin
                r_pend_val <= value;
            end

            if (w_apply) begin
                // A load landing on the wrap tick goes straight to the display.
                if (load) begin
                    r_shown <= value;
                end else if (r_pending) begin
                    r_shown <= r_pend_val;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign sel        = r_sel;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

    always_comb begin
        an  = 4'b1111;
        hex = 4'h0;
        if (!reset) begin
            an  = ~(4'b0001 << r_sel) | ~digit_en;
            hex = r_shown[{r_sel, 2'b00} +: 4];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Purpose  : Directed self-checking bench for seg_scan_driver (DIGIT_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic [3:0]  digit_en;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [3:0]  hex;
    logic        pending;
    logic        frame_done;

    int n_total;
    int n_bad;
    int ecnt;

    logic [15:0] an_scan;

    seg_scan_driver #(
        .DIGIT_CYCLES (4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .digit_en   (digit_en),
        .sel        (sel),
        .an         (an),
        .hex        (hex),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, ecnt, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic run_to(input int n);
        while (ecnt < n) step();
    endtask

    // Called right after a wrap edge; walks one full frame and ends on the next wrap.
    task automatic chk_frame(input logic [15:0] exp_hex, input logic [15:0] exp_an);
        for (int d = 0; d < 4; d++) begin
            chk("frame_sel", 16'(sel), 16'(d));
            chk("frame_hex", 16'(hex), 16'(exp_hex[4*d +: 4]));
            chk("frame_an", 16'(an), 16'(exp_an[4*d +: 4]));
            chk("frame_pending", 16'(pending), 16'h0);
            chk("frame_done", 16'(frame_done), (d == 0) ? 16'h1 : 16'h0);
            repeat (4) step();
        end
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        ecnt     = 0;
        an_scan  = 16'h7BDE;
        reset    = 1'b1;
        load     = 1'b1;
        value    = 16'hFFFF;
        digit_en = 4'b1111;

        // Reset held with a load request active
        repeat (3) begin
            step();
            chk("rst_an", 16'(an), 16'hF);
            chk("rst_sel", 16'(sel), 16'h0);
            chk("rst_hex", 16'(hex), 16'h0);
            chk("rst_pending", 16'(pending), 16'h0);
            chk("rst_frame_done", 16'(frame_done), 16'h0);
        end
        reset = 1'b0;
        load  = 1'b0;
        ecnt  = 0;
        #1;
        chk("release_an", 16'(an), 16'hE);

        // Free scan over one frame and into the next
        for (int e = 1; e <= 20; e++) begin
            step();
            chk("scan_sel", 16'(sel), 16'((ecnt / 4) % 4));
            chk("scan_an", 16'(an), 16'(an_scan[4*((ecnt / 4) % 4) +: 4]));
            chk("scan_frame_done", 16'(frame_done), (ecnt == 16) ? 16'h1 : 16'h0);
        end

        // Deferred load issued while sel = 1
        chk("defer_sel", 16'(sel), 16'h1);
        value = 16'hBEEF;
        load  = 1'b1;
        step();
        load  = 1'b0;
        while (ecnt < 32) begin
            chk("defer_pending", 16'(pending), 16'h1);
            chk("defer_hex", 16'(hex), 16'h0);
            step();
        end
        chk_frame(16'hBEEF, 16'h7BDE);

        // Last load before the wrap wins
        step();
        value = 16'h1234;
        load  = 1'b1;
        step();
        load  = 1'b0;
        step();
        step();
        value = 16'hABCD;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk("lastwins_pending", 16'(pending), 16'h1);
        run_to(64);
        chk_frame(16'hABCD, 16'h7BDE);

        // Load exactly on the wrap tick bypasses the pending register
        run_to(95);
        chk("bypass_pre_pending", 16'(pending), 16'h0);
        value = 16'h5A5A;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk_frame(16'h5A5A, 16'h7BDE);

        // Blanking digits 1 and 3
        digit_en = 4'b0101;
        #1;
        chk_frame(16'h5A5A, 16'hFBFE);
        digit_en = 4'b1111;
        step();
        digit_en = 4'b1110;
        #1;
        chk("toggle_off_an", 16'(an), 16'hF);
        digit_en = 4'b1111;
        #1;
        chk("toggle_on_an", 16'(an), 16'hE);

        // Reset mid-frame with a pending value
        run_to(137);
        value = 16'h9999;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk("midrst_pre_pending", 16'(pending), 16'h1);
        chk("midrst_pre_sel", 16'(sel), 16'h2);
        reset = 1'b1;
        #1;
        chk("midrst_an", 16'(an), 16'hF);
        chk("midrst_hex", 16'(hex), 16'h0);
        step();
        reset = 1'b0;
        ecnt  = 0;
        #1;
        chk("postrst_pending", 16'(pending), 16'h0);
        chk("postrst_sel", 16'(sel), 16'h0);
        chk("postrst_hex", 16'(hex), 16'h0);
        chk("postrst_an", 16'(an), 16'hE);
        chk("postrst_frame_done", 16'(frame_done), 16'h0);
        repeat (3) step();
        chk("postrst_sel_hold", 16'(sel), 16'h0);
        step();
        chk("postrst_sel_adv", 16'(sel), 16'h1);
        run_to(16);
        chk_frame(16'h0000, 16'h7BDE);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
